rv32i_regfile: RTL and testbench
================================

Name: rv32i_regfile

Overview:
- Architectural integer register file for the RV32I 6-stage pipeline, x0..x31.
- Read responder for the RF stage: it receives ra1/ra2 and returns rd1/rd2 in the same cycle, so the RF stage can latch them into its pipeline register.
- A single write port is driven by the writeback stage.
- Storage is cleared by a sequential walk after reset, so the array can map onto RAM-style storage. The pipeline is held off by init_busy until the clear completes.

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 32, number of registers; must be a power of two. Register 0 is hardwired zero.
- AW, 5, address width; equals log2(NREG).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ra1  input  AW  read address, port 1 (rs1).
- ra2  input  AW  read address, port 2 (rs2).
- rd1  output  WIDTH  read data, port 1; combinational.
- rd2  output  WIDTH  read data, port 2; combinational.
- we3  input  1  write enable from writeback.
- wa3  input  AW  write address.
- wd3  input  WIDTH  write data.
- init_busy  output  1  clear walk in progress; the pipeline ORs this into the RF stage stall and the fetch stall.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- States: CLEAR, READY. State plus clear index clr_idx (AW bits).
- Reset:
  - While reset=1 at a clk edge: state<=CLEAR, clr_idx<=1, init_busy=1.
  - Array contents are not reset directly; the walk zeroes them.
- CLEAR:
  - Each cycle write 0 to reg[clr_idx], then clr_idx<=clr_idx+1.
  - When clr_idx==NREG-1 is written, state<=READY next edge.
  - The walk lasts exactly NREG-1 = 31 cycles after reset deasserts. init_busy falls on the edge after reg[31] is cleared.
- init_busy = (state==CLEAR); registered, no combinational path from inputs.
- Writes during CLEAR (we3=1): dropped silently; the walk has priority and no write is queued.
- Reads during CLEAR: rd1=rd2=0 regardless of address or bypass.
- Write in READY: if we3=1 and wa3!=0, reg[wa3]<=wd3 at the rising edge. Writes to x0 have no effect.
- Read in READY, per port n (1,2), combinational priority:
  1. ran==0 gives 0.
  2. Else if we3=1 and wa3==ran, return wd3 (write-through bypass, so a same-cycle writeback is visible to the RF stage).
  3. Else return reg[ran].
- ra1==ra2: both ports return identical data; bypass applies to both.
- Reset asserted mid-walk: clr_idx restarts at 1; the full 31-cycle walk repeats after release.
- Reset asserted in READY: returns to CLEAR; all previous contents are zeroed by the new walk.
- No read latency: rd1/rd2 are valid within the cycle ra1/ra2 are presented. The RF stage flop captures them.
- No X propagation: after the walk completes, every location reads a defined value.
- Width rules:
  - clr_idx increments modulo 2^AW.
  - The terminal compare uses NREG-1, so the counter never wraps to 0 in normal operation.

Test Plan:
- Reset held 3 cycles, then released: init_busy=1 for exactly 31 cycles after release, then 0. Afterwards reading x1..x31 on both ports returns 0x00000000.
- After init: write x5=0xDEADBEEF; next cycle ra1=5, ra2=5 gives rd1=rd2=0xDEADBEEF. Then write x0=0x12345678; ra1=0 gives rd1=0.
- Bypass:
  - Same cycle we3=1, wa3=7, wd3=0xA5A5A5A5, ra1=7, ra2=8 gives rd1=0xA5A5A5A5 and rd2=old x8.
  - Next cycle with we3=0, rd1 is still 0xA5A5A5A5.
- Write during CLEAR: we3=1, wa3=3, wd3=0xFFFFFFFF at cycle 2 of the walk gives rd1 (ra1=3) = 0 during the walk, and x3=0 after init_busy falls.
- Reset mid-walk: assert reset at walk cycle 20 for 1 cycle. init_busy stays high for 31 more cycles after release. Then write x31=1 and read it back as 0x00000001.
- Reset in READY: fill x1..x31 with index values, assert reset. After the walk, every register reads 0 and init_busy=0.

Source files
------------

// File: rtl/rv32i_regfile.sv
// Architectural integer register file x0..x31 for the RV32I pipeline.
// Two combinational read ports with write-through bypass and one write port
// from writeback. After reset, a sequential walk zeroes x1..x(NREG-1) so the
// array can map onto RAM-style storage; init_busy_o holds the pipeline off
// until the walk completes.
module rv32i_regfile #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [AW-1:0]    ra1_i,
  input  logic [AW-1:0]    ra2_i,
  output logic [WIDTH-1:0] rd1_o,
  output logic [WIDTH-1:0] rd2_o,
  input  logic             we3_i,
  input  logic [AW-1:0]    wa3_i,
  input  logic [WIDTH-1:0] wd3_i,
  output logic             init_busy_o
);

  typedef enum logic {StClear, StReady} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic             clr_last;
  logic [WIDTH-1:0] mem_q [NREG];

  // Terminal compare against NREG-1 keeps the index from ever wrapping to x0.
  assign clr_last = (clr_idx_q == AW'(NREG - 1));

  // Walk sequencing: advance the clear index each cycle, leave CLEAR after the last entry.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == StClear) begin
      clr_idx_d = clr_idx_q + AW'(1);
      if (clr_last) begin
        state_d = StReady;
      end
    end
  end

  // Control state with synchronous reset; the walk restarts at x1 on every reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StClear;
      clr_idx_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Storage: the walk owns the write port while clearing; writeback writes are dropped then.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == StClear) begin
        mem_q[clr_idx_q] <= '0;
      end else if (we3_i && (wa3_i != '0)) begin
        mem_q[wa3_i] <= wd3_i;
      end
    end
  end

  // Busy comes straight from the state flop, so no input reaches it combinationally.
  assign init_busy_o = (state_q == StClear);

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] data;
    if (state_q == StClear) begin
      data = '0;
    end else if (ra == '0) begin
      data = '0;
    end else if (we3_i && (wa3_i == ra)) begin
      // Same-cycle writeback is forwarded so the RF stage never sees stale data.
      data = wd3_i;
    end else begin
      data = mem_q[ra];
    end
    return data;
  endfunction

  // Combinational read ports with x0 forcing and write-through bypass.
  always_comb begin
    rd1_o = read_port(ra1_i);
    rd2_o = read_port(ra2_i);
  end

endmodule

// File: tb/tb_rv32i_regfile.sv
// Self-checking bench for rv32i_regfile: directed scenarios plus a randomized
// phase, all checked against an array-based reference model of the register file.
module tb_rv32i_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  ra1, ra2, wa3;
  logic [31:0] rd1, rd2, wd3;
  logic        we3;
  logic        init_busy;

  int total;
  int bad;

  // Reference model: register contents and remaining walk cycles.
  logic [31:0] m_mem [32];
  int          walk_left;

  rv32i_regfile #(
    .WIDTH(32),
    .NREG (32),
    .AW   (5)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .ra1_i      (ra1),
    .ra2_i      (ra2),
    .rd1_o      (rd1),
    .rd2_o      (rd2),
    .we3_i      (we3),
    .wa3_i      (wa3),
    .wd3_i      (wd3),
    .init_busy_o(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (walk_left > 0) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (we3 && wa3 == ra) return wd3;
    return m_mem[ra];
  endfunction

  function automatic logic exp_busy();
    return walk_left > 0;
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      walk_left = 31;
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    end else if (walk_left > 0) begin
      walk_left--;
    end else if (we3 && wa3 != 5'd0) begin
      m_mem[wa3] = wd3;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; wa3 = 5'd0; wd3 = 32'h0; ra1 = 5'd0; ra2 = 5'd0;
  endtask

  // Run until busy drops; returns the number of busy cycles seen (bounded).
  task automatic wait_walk(output int n);
    n = 0;
    #1;
    while (init_busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    wait_walk(n);
    total++;
    if (n != 31) begin
      bad++; $display("FAIL reset_busy_len: got %0d cycles want 31", n);
    end
    total++;
    if (init_busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy_end: got %b want 0", init_busy);
    end
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(32 - i);
      #1;
      total++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        bad++; $display("FAIL reset_zero x%0d: got %h/%h want 0", i, rd1, rd2);
      end
    end
  endtask

  task automatic test_write_read();
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    total++;
    if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_read x5: got %h/%h want deadbeef", rd1, rd2);
    end
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h12345678; ra1 = 5'd0;
    #1;
    total++;
    if (rd1 !== 32'h0) begin
      bad++; $display("FAIL x0_bypass: got %h want 0", rd1);
    end
    tick();
    we3 = 1'b0;
    #1;
    total++;
    if (rd1 !== 32'h0) begin
      bad++; $display("FAIL x0_write: got %h want 0", rd1);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old8;
    old8 = m_mem[8];
    we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hA5A5A5A5; ra1 = 5'd7; ra2 = 5'd8;
    #1;
    total++;
    if (rd1 !== 32'hA5A5A5A5 || rd2 !== old8) begin
      bad++; $display("FAIL bypass: got %h/%h want a5a5a5a5/%h", rd1, rd2, old8);
    end
    tick();
    we3 = 1'b0;
    #1;
    total++;
    if (rd1 !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL bypass_hold: got %h want a5a5a5a5", rd1);
    end
  endtask

  task automatic test_write_during_clear();
    int n;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    // Walk cycle 2: the x3 write must be dropped and reads forced to zero.
    we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hFFFFFFFF; ra1 = 5'd3; ra2 = 5'd3;
    #1;
    total++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      bad++; $display("FAIL clear_read x3: got %h/%h want 0", rd1, rd2);
    end
    tick();
    // Keep hammering writes for the rest of the walk; none may land.
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      we3 = 1'b1; wa3 = 5'($urandom_range(1, 31)); wd3 = $urandom | 32'h1;
      ra1 = wa3; ra2 = 5'($urandom);
      #1;
      total++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        bad++; $display("FAIL clear_read_walk: got %h/%h want 0", rd1, rd2);
      end
      tick();
      n++;
    end
    total++;
    if (n != 29) begin
      bad++; $display("FAIL clear_busy_len: got %0d remaining want 29", n);
    end
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      total++;
      if (rd1 !== 32'h0) begin
        bad++; $display("FAIL clear_dropped x%0d: got %h want 0", i, rd1);
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    int n;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_walk(n);
    total++;
    if (n != 31) begin
      bad++; $display("FAIL midwalk_busy_len: got %0d cycles want 31", n);
    end
    we3 = 1'b1; wa3 = 5'd31; wd3 = 32'h1;
    tick();
    we3 = 1'b0; ra1 = 5'd31; ra2 = 5'd31;
    #1;
    total++;
    if (rd1 !== 32'h1 || rd2 !== 32'h1) begin
      bad++; $display("FAIL midwalk_x31: got %h/%h want 00000001", rd1, rd2);
    end
  endtask

  task automatic test_reset_in_ready();
    int n;
    for (int i = 1; i < 32; i++) begin
      we3 = 1'b1; wa3 = 5'(i); wd3 = 32'(i);
      tick();
    end
    we3 = 1'b0; ra1 = 5'd17; ra2 = 5'd30;
    #1;
    total++;
    if (rd1 !== 32'd17 || rd2 !== 32'd30) begin
      bad++; $display("FAIL fill: got %h/%h want 11/1e", rd1, rd2);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_walk(n);
    total++;
    if (n != 31 || init_busy !== 1'b0) begin
      bad++; $display("FAIL ready_reset_busy: got %0d/%b want 31/0", n, init_busy);
    end
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      total++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        bad++; $display("FAIL ready_reset_zero x%0d: got %h/%h want 0", i, rd1, rd2);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      we3   = $urandom_range(0, 1) == 1;
      wa3   = 5'($urandom);
      wd3   = $urandom;
      ra1   = 5'($urandom);
      ra2   = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
      if ($urandom_range(0, 2) == 0) ra1 = wa3;
      #1;
      e1 = exp_rd(ra1);
      e2 = exp_rd(ra2);
      total++;
      if (rd1 !== e1 || rd2 !== e2 || init_busy !== exp_busy()) begin
        bad++;
        $display("FAIL random c%0d: got %h/%h/%b want %h/%h/%b",
                 c, rd1, rd2, init_busy, e1, e2, exp_busy());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    walk_left = 0;
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_write_during_clear();
    test_reset_mid_walk();
    test_reset_in_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
